csel_adder_pipe: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor.
- WIDTH-bit operands are split into SEG-bit segments, with one pipeline stage per segment.
- In each stage, the segment is computed twice (carry-in 0 and carry-in 1). The registered carry from the previous stage selects the result.
- Sits in the datapath as a multi-cycle ALU add unit with a valid/ready handshake. It replaces single-cycle fixed 4-bit carry-select adders where width or timing demands it.

---
 rtl/csel_adder_pipe.sv | 148 ++++++++++++++
 tb/tb_csel_adder_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: one SEG-bit segment per stage, valid/ready with global stall.
// Optional zero/overflow flags are built when CSEL_ADDER_FLAGS_EN is defined.
module csel_adder_pipe #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             zero,
   output logic             ovf
);

   localparam int NSTG = WIDTH / SEG;

   if ((SEG < 1) || ((WIDTH % SEG) != 0)) begin : g_param_chk
      $error("csel_adder_pipe: WIDTH must be a non-zero multiple of SEG");
   end

   logic             stall_s;
   logic             en_s;
   logic             vld_q;
   logic             co_q;
   logic [WIDTH-1:0] sum_q;
`ifdef CSEL_ADDER_FLAGS_EN
   logic             zero_q;
   logic             ovf_q;
`endif

   assign stall_s   = vld_q & ~out_ready;
   assign en_s      = ~stall_s;
   assign in_ready  = en_s;
   assign out_valid = vld_q;
   assign sum       = sum_q;
   assign co        = co_q;
`ifdef CSEL_ADDER_FLAGS_EN
   assign zero      = zero_q;
   assign ovf       = ovf_q;
`else
   assign zero      = 1'b0;
   assign ovf       = 1'b0;
`endif

   // acc holds {operand A bits not yet added, finished sum bits}; brem holds the B bits still ahead.
   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam int BIN = WIDTH - k * SEG;
      localparam int REM = BIN - SEG;

      logic [WIDTH-1:0] acc_in_s;
      logic [BIN-1:0]   b_in_s;
      logic             sub_in_s;
      logic             cin_s;
      logic             vld_in_s;
      logic [SEG-1:0]   seg_b_s;
      logic [SEG:0]     s0_s;
      logic [SEG:0]     s1_s;
      logic [SEG-1:0]   res_s;
      logic             cout_s;
      logic [WIDTH-1:0] acc_d_s;

      if (k == 0) begin : g_src
         assign acc_in_s = a;
         assign b_in_s   = b;
         assign sub_in_s = sub;
         assign cin_s    = sub ? 1'b1 : ci;
         assign vld_in_s = in_valid;
      end else begin : g_src
         assign acc_in_s = g_stg[k-1].g_mid.acc_q;
         assign b_in_s   = g_stg[k-1].g_mid.brem_q;
         assign sub_in_s = g_stg[k-1].g_mid.sub_q;
         assign cin_s    = g_stg[k-1].g_mid.cy_q;
         assign vld_in_s = g_stg[k-1].g_mid.vld_q;
      end

      // Both carry hypotheses for this segment, picked by the incoming registered carry.
      always_comb begin
         seg_b_s = b_in_s[SEG-1:0] ^ {SEG{sub_in_s}};
         s0_s    = {1'b0, acc_in_s[k*SEG +: SEG]} + {1'b0, seg_b_s};
         s1_s    = {1'b0, acc_in_s[k*SEG +: SEG]} + {1'b0, seg_b_s} + {{SEG{1'b0}}, 1'b1};
         res_s   = cin_s ? s1_s[SEG-1:0] : s0_s[SEG-1:0];
         cout_s  = s0_s[SEG] | (s1_s[SEG] & cin_s);
         acc_d_s = acc_in_s;
         acc_d_s[k*SEG +: SEG] = res_s;
      end

      if (k < NSTG - 1) begin : g_mid
         logic [WIDTH-1:0] acc_q;
         logic [REM-1:0]   brem_q;
         logic             sub_q;
         logic             cy_q;
         logic             vld_q;

         // Intermediate stage register; data only loads for real beats so bubbles leave it untouched.
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q  <= 1'b0;
               acc_q  <= {WIDTH{1'b0}};
               brem_q <= {REM{1'b0}};
               sub_q  <= 1'b0;
               cy_q   <= 1'b0;
            end else if (en_s) begin
               vld_q <= vld_in_s;
               if (vld_in_s) begin
                  acc_q  <= acc_d_s;
                  brem_q <= b_in_s[BIN-1:SEG];
                  sub_q  <= sub_in_s;
                  cy_q   <= cout_s;
               end
            end
         end
      end else begin : g_last
         // Output stage register: final sum, carry and (optionally) flags.
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q  <= 1'b0;
               sum_q  <= {WIDTH{1'b0}};
               co_q   <= 1'b0;
`ifdef CSEL_ADDER_FLAGS_EN
               zero_q <= 1'b0;
               ovf_q  <= 1'b0;
`endif
            end else if (en_s) begin
               vld_q <= vld_in_s;
               if (vld_in_s) begin
                  sum_q  <= acc_d_s;
                  co_q   <= cout_s;
`ifdef CSEL_ADDER_FLAGS_EN
                  zero_q <= (acc_d_s == {WIDTH{1'b0}});
                  // Top segment of acc still holds A's MSB here; seg_b_s[SEG-1] is B' MSB.
                  ovf_q  <= (acc_in_s[WIDTH-1] == seg_b_s[SEG-1]) &&
                            (acc_d_s[WIDTH-1] != acc_in_s[WIDTH-1]);
`endif
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench for csel_adder_pipe (WIDTH=16, SEG=4): directed vectors, latency, stall and reset.
module tb_csel_adder_pipe;

   localparam int WIDTH = 16;
   localparam int SEG   = 4;
   localparam int NSTG  = WIDTH / SEG;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             co;
   logic             zero;
   logic             ovf;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             co;
      logic             zero;
      logic             ovf;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   csel_adder_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .co(co), .zero(zero), .ovf(ovf)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                  input logic mci, input logic msub);
      exp_t             e;
      logic [WIDTH-1:0] bx;
      logic [WIDTH:0]   full;
      bx     = msub ? ~mb : mb;
      full   = {1'b0, ma} + {1'b0, bx} + {{WIDTH{1'b0}}, (msub ? 1'b1 : mci)};
      e.sum  = full[WIDTH-1:0];
      e.co   = full[WIDTH];
`ifdef CSEL_ADDER_FLAGS_EN
      e.zero = (full[WIDTH-1:0] == '0);
      e.ovf  = (ma[WIDTH-1] == bx[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
`else
      e.zero = 1'b0;
      e.ovf  = 1'b0;
`endif
      return e;
   endfunction

   // Monitor on the falling edge: scoreboard push/pop, stall hold and in_ready checks.
   logic             stall_prev = 1'b0;
   logic [WIDTH-1:0] sum_prev;
   logic             co_prev;
   logic             zero_prev;
   logic             ovf_prev;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_sum", 32'(sum), 32'(sum_prev));
            check_eq("hold_co", 32'(co), 32'(co_prev));
            check_eq("hold_flags", 32'({zero, ovf}), 32'({zero_prev, ovf_prev}));
         end
         if (out_valid && !out_ready) check_eq("stall_in_ready", 32'(in_ready), 32'd0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check_eq("sum", 32'(sum), 32'(e.sum));
               check_eq("co", 32'(co), 32'(e.co));
               check_eq("zero", 32'(zero), 32'(e.zero));
               check_eq("ovf", 32'(ovf), 32'(e.ovf));
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, ci, sub));
         stall_prev = out_valid && !out_ready;
         sum_prev   = sum;
         co_prev    = co;
         zero_prev  = zero;
         ovf_prev   = ovf;
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
   task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic tci, input logic tsub);
      bit done;
      done     = 1'b0;
      a        = ta;
      b        = tb_v;
      ci       = tci;
      sub      = tsub;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      if (!done) check_eq("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      check_eq("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   // Beat was just accepted: out_valid must stay low for NSTG-1 cycles, then rise.
   task automatic check_latency(input string tag);
      for (int i = 0; i < NSTG - 1; i++) begin
         @(negedge clk);
         check_eq({tag, "_early"}, 32'(out_valid), 32'd0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check_eq({tag, "_on_time"}, 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      ci        = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_sum", 32'(sum), 32'd0);
      check_eq("rst_co", 32'(co), 32'd0);
      check_eq("rst_flags", 32'({zero, ovf}), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      send(16'h00FF, 16'h0001, 1'b0, 1'b0);
      check_latency("lat1");
      drain();
      send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      drain();
      send(16'h8000, 16'h0001, 1'b0, 1'b1);
      drain();
      send(16'h0003, 16'h0005, 1'b1, 1'b1);
      drain();

      fork
         begin
            for (int i = 0; i < 8; i++) begin
               r = $urandom();
               send(r[15:0], r[31:16], r[0] ^ r[20], (i % 3) == 1);
            end
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      for (int i = 0; i < 3; i++) begin
         r = $urandom();
         send(r[15:0], r[31:16], 1'b1, 1'b0);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_sum", 32'(sum), 32'd0);
      check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
      repeat (8) @(posedge clk);
      #1;
      send(16'h1234, 16'h0FED, 1'b1, 1'b0);
      check_latency("lat_after_rst");
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
